// File: rtl/temp_mon_pkg.sv
// rtl/temp_mon_pkg.sv - shared state encodings and default thresholds for temperature monitoring
package temp_mon_pkg;

    typedef enum logic [1:0] {
        ST_COLD      = 2'b00,
        ST_PEND_HOT  = 2'b01,
        ST_HOT       = 2'b10,
        ST_PEND_COLD = 2'b11
    } temp_state_e;

    localparam int TH_ON_DEF_C  = 4;
    localparam int TH_OFF_DEF_C = 3;

    function automatic logic state_alarm(input temp_state_e s);
        return (s == ST_HOT) || (s == ST_PEND_COLD);
    endfunction

endpackage

// File: rtl/consec_counter.sv
// rtl/consec_counter.sv - saturating consecutive-event counter with clear, increment and reach flag
module consec_counter #(
    parameter int DEB = 3,
    parameter int CW  = $clog2(DEB + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic reach_on_inc
);

    localparam logic [CW-1:0] DEB_C  = CW'(DEB);
    localparam logic [CW-1:0] LAST_C = CW'(DEB - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // clr together with inc restarts the run at this qualifying sample
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? ONE_C : '0;
        end else if (inc && (cnt_q != DEB_C)) begin
            cnt_d = cnt_q + ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // True when one more increment brings the count to DEB
    assign reach_on_inc = (cnt_q >= LAST_C);

endmodule

// File: rtl/temp_threshold_monitor.sv
// rtl/temp_threshold_monitor.sv - debounced hysteresis temperature alarm (option: STICKY_ALARM_EN)
module temp_threshold_monitor
    import temp_mon_pkg::*;
#(
    parameter int W          = 3,
    parameter int TH_ON_DEF  = TH_ON_DEF_C,
    parameter int TH_OFF_DEF = TH_OFF_DEF_C,
    parameter int DEB        = 3,
    parameter int CW         = $clog2(DEB + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_valid,
    input  logic [W-1:0] temp,
    input  logic         cfg_we,
    input  logic [W-1:0] th_on,
    input  logic [W-1:0] th_off,
    input  logic         alarm_ack,
    output logic         alarm,
    output logic         alarm_set,
    output logic         alarm_clr
);

    localparam logic [W-1:0] TH_ON_RST  = W'(TH_ON_DEF);
    localparam logic [W-1:0] TH_OFF_RST = W'((TH_OFF_DEF > TH_ON_DEF) ? TH_ON_DEF : TH_OFF_DEF);
    localparam logic         DEB_ONE    = (DEB == 1);

    temp_state_e  state_q, state_d;
    logic         alarm_q, alarm_d;
    logic         alarm_set_q, alarm_set_d;
    logic         alarm_clr_q, alarm_clr_d;
    logic [W-1:0] th_on_q, th_on_d;
    logic [W-1:0] th_off_q, th_off_d;

    logic hot, cold;
    logic cnt_clr, cnt_inc, reach_on_inc;
    logic fsm_alarm;

    consec_counter #(
        .DEB (DEB),
        .CW  (CW)
    ) u_consec_counter (
        .clk          (clk),
        .reset        (reset),
        .clr          (cnt_clr),
        .inc          (cnt_inc),
        .reach_on_inc (reach_on_inc)
    );

    assign hot  = (temp >= th_on_q);
    assign cold = (temp < th_off_q);

    // Off-threshold is clamped to the on-threshold so hysteresis is never negative
    always_comb begin
        th_on_d  = th_on_q;
        th_off_d = th_off_q;
        if (cfg_we) begin
            th_on_d  = th_on;
            th_off_d = (th_off > th_on) ? th_on : th_off;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (sample_valid) begin
            unique case (state_q)
                ST_COLD: begin
                    cnt_clr = 1'b1;
                    if (hot) begin
                        cnt_inc = 1'b1;
                        state_d = DEB_ONE ? ST_HOT : ST_PEND_HOT;
                    end
                end
                ST_PEND_HOT: begin
                    if (hot) begin
                        cnt_inc = 1'b1;
                        if (reach_on_inc) state_d = ST_HOT;
                    end else begin
                        cnt_clr = 1'b1;
                        state_d = ST_COLD;
                    end
                end
                ST_HOT: begin
                    cnt_clr = 1'b1;
                    if (cold) begin
                        cnt_inc = 1'b1;
                        state_d = DEB_ONE ? ST_COLD : ST_PEND_COLD;
                    end
                end
                ST_PEND_COLD: begin
                    if (cold) begin
                        cnt_inc = 1'b1;
                        if (reach_on_inc) state_d = ST_COLD;
                    end else begin
                        cnt_clr = 1'b1;
                        state_d = ST_HOT;
                    end
                end
                default: state_d = ST_COLD;
            endcase
        end
    end

    assign fsm_alarm = state_alarm(state_d);

`ifdef STICKY_ALARM_EN
    // A latched alarm is released only by an acknowledge while the FSM sits in COLD
    always_comb begin
        alarm_d = fsm_alarm;
        if (alarm_q) begin
            alarm_d = fsm_alarm || !((state_q == ST_COLD) && alarm_ack);
        end
    end
`else
    logic unused_alarm_ack;
    assign unused_alarm_ack = alarm_ack;

    always_comb begin
        alarm_d = fsm_alarm;
    end
`endif

    assign alarm_set_d = alarm_d & ~alarm_q;
    assign alarm_clr_d = ~alarm_d & alarm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_COLD;
            alarm_q     <= 1'b0;
            alarm_set_q <= 1'b0;
            alarm_clr_q <= 1'b0;
            th_on_q     <= TH_ON_RST;
            th_off_q    <= TH_OFF_RST;
        end else begin
            state_q     <= state_d;
            alarm_q     <= alarm_d;
            alarm_set_q <= alarm_set_d;
            alarm_clr_q <= alarm_clr_d;
            th_on_q     <= th_on_d;
            th_off_q    <= th_off_d;
        end
    end

    assign alarm     = alarm_q;
    assign alarm_set = alarm_set_q;
    assign alarm_clr = alarm_clr_q;

endmodule
